// File: rtl/db_req_arb_pkg.sv
// db_req_arb_pkg: shared constants for the db_cont request arbiter.
// Op/flag encodings and arbiter FSM states.
package db_req_arb_pkg;

  localparam logic SET_REQ = 1'b1;
  localparam logic GET_REQ = 1'b0;

  typedef enum logic [3:0] {
    FLAG_IDLE    = 4'b0001,
    FLAG_SUSPECT = 4'b0010,
    FLAG_ARREST  = 4'b0100,
    FLAG_EXPIRE  = 4'b1000
  } flag_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } arb_st_e;

endpackage

// File: rtl/db_req_arb_if.sv
// db_req_arb_if: requester and engine bundle for db_req_arb.
// slave = arbiter side, master = requesters plus engine side.
interface db_req_arb_if #(
  parameter int NREQ      = 2,
  parameter int HASH_SIZE = 32,
  parameter int KEY_SIZE  = 96,
  parameter int VAL_SIZE  = 32
);

  logic [NREQ-1:0]           req_valid;
  logic [NREQ-1:0]           req_ready;
  logic [4*NREQ-1:0]         req_op;
  logic [HASH_SIZE*NREQ-1:0] req_hash;
  logic [KEY_SIZE*NREQ-1:0]  req_key;
  logic [VAL_SIZE*NREQ-1:0]  req_value;
  logic [NREQ-1:0]           rsp_valid;
  logic                      rsp_hit;
  logic [3:0]                rsp_flag;
  logic                      db_in_valid;
  logic [3:0]                db_in_op;
  logic [HASH_SIZE-1:0]      db_in_hash;
  logic [KEY_SIZE-1:0]       db_in_key;
  logic [VAL_SIZE-1:0]       db_in_value;
  logic                      db_out_valid;
  logic [3:0]                db_out_flag;
  logic                      busy;

  modport slave (
    input  req_valid, req_op, req_hash,
    input  req_key, req_value,
    input  db_out_valid, db_out_flag,
    output req_ready, rsp_valid,
    output rsp_hit, rsp_flag,
    output db_in_valid, db_in_op,
    output db_in_hash, db_in_key,
    output db_in_value, busy
  );

  modport master (
    output req_valid, req_op, req_hash,
    output req_key, req_value,
    output db_out_valid, db_out_flag,
    input  req_ready, rsp_valid,
    input  rsp_hit, rsp_flag,
    input  db_in_valid, db_in_op,
    input  db_in_hash, db_in_key,
    input  db_in_value, busy
  );

endinterface

// File: rtl/db_req_arb_rr_pick.sv
// rr_pick: combinational round-robin priority picker.
// i_req/i_last in; o_gnt one-hot, o_idx index, o_any.
module rr_pick #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_last,
  output logic [N-1:0]  o_gnt,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);

  logic [N-1:0] w_hi;
  logic [N-1:0] w_sel;

  // Requests above the last winner take priority;
  // otherwise wrap to the lowest request overall.
  always_comb begin
    w_hi = '0;
    for (int i = 0; i < N; i++)
      w_hi[i] = i_req[i] && (i > int'(i_last));
  end

  assign w_sel = (|w_hi) ? w_hi : i_req;

  always_comb begin
    o_idx = '0;
    for (int i = N - 1; i >= 0; i--)
      if (w_sel[i]) o_idx = IW'(i);
  end

  assign o_any = |i_req;
  assign o_gnt = o_any ? (N'(1) << o_idx) : '0;

endmodule

// File: rtl/db_req_arb.sv
// db_req_arb: round-robin share of one db_cont engine.
// clk, rst_n; bus = requesters + engine (db_req_arb_if.slave).
module db_req_arb
  import db_req_arb_pkg::*;
#(
  parameter int NREQ      = 2,
  parameter int HASH_SIZE = 32,
  parameter int KEY_SIZE  = 96,
  parameter int VAL_SIZE  = 32,
  parameter int HOLD_CYC  = 6
) (
  input logic        clk,
  input logic        rst_n,
  db_req_arb_if.slave bus
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(HOLD_CYC) + 1;

  arb_st_e               r_state;
  logic [IW-1:0]         r_last;
  logic [IW-1:0]         r_gidx;
  logic [CW-1:0]         r_cnt;
  logic                  r_hit;
  logic [3:0]            r_flag;
  logic                  r_in_valid;
  logic [3:0]            r_op;
  logic [HASH_SIZE-1:0]  r_hash;
  logic [KEY_SIZE-1:0]   r_key;
  logic [VAL_SIZE-1:0]   r_val;
  logic [NREQ-1:0]       r_rsp_valid;
  logic                  r_rsp_hit;
  logic [3:0]            r_rsp_flag;

  logic [NREQ-1:0]       w_gnt;
  logic [IW-1:0]         w_gidx;
  logic                  w_any;
  logic                  w_take;
  logic                  w_hit_nxt;
  logic [3:0]            w_flag_nxt;
  logic [3:0]            w_op;
  logic [HASH_SIZE-1:0]  w_hash;
  logic [KEY_SIZE-1:0]   w_key;
  logic [VAL_SIZE-1:0]   w_val;

  rr_pick #(
    .N  (NREQ),
    .IW (IW)
  ) u_pick (
    .i_req  (bus.req_valid),
    .i_last (r_last),
    .o_gnt  (w_gnt),
    .o_idx  (w_gidx),
    .o_any  (w_any)
  );

  assign w_take = (r_state == ST_IDLE) && w_any;

  // rst_n gate keeps ready low while reset is held.
  assign bus.req_ready =
    (w_take && rst_n) ? w_gnt : '0;

  always_comb begin
    w_op   = '0;
    w_hash = '0;
    w_key  = '0;
    w_val  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_gidx == IW'(i)) begin
        w_op   = bus.req_op[i*4 +: 4];
        w_hash = bus.req_hash[i*HASH_SIZE +: HASH_SIZE];
        w_key  = bus.req_key[i*KEY_SIZE +: KEY_SIZE];
        w_val  = bus.req_value[i*VAL_SIZE +: VAL_SIZE];
      end
    end
  end

  // Only the first engine strobe of a window counts.
  assign w_hit_nxt  = r_hit | bus.db_out_valid;
  assign w_flag_nxt = (r_hit || !bus.db_out_valid) ?
                      r_flag : bus.db_out_flag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_last      <= IW'(NREQ - 1);
      r_gidx      <= '0;
      r_cnt       <= '0;
      r_hit       <= 1'b0;
      r_flag      <= '0;
      r_in_valid  <= 1'b0;
      r_op        <= '0;
      r_hash      <= '0;
      r_key       <= '0;
      r_val       <= '0;
      r_rsp_valid <= '0;
      r_rsp_hit   <= 1'b0;
      r_rsp_flag  <= '0;
    end else begin
      r_in_valid  <= 1'b0;
      r_rsp_valid <= '0;
      unique case (r_state)
        ST_IDLE: begin
          if (w_take) begin
            r_op       <= w_op;
            r_hash     <= w_hash;
            r_key      <= w_key;
            r_val      <= w_val;
            r_gidx     <= w_gidx;
            r_in_valid <= 1'b1;
            r_state    <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          r_cnt   <= '0;
          r_hit   <= 1'b0;
          r_flag  <= '0;
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          r_hit  <= w_hit_nxt;
          r_flag <= w_flag_nxt;
          r_cnt  <= r_cnt + CW'(1);
          if (r_cnt == CW'(HOLD_CYC - 1)) begin
            r_rsp_valid <= NREQ'(1) << r_gidx;
            r_rsp_hit   <= w_hit_nxt;
            r_rsp_flag  <= w_flag_nxt;
            r_state     <= ST_RESP;
          end
        end
        ST_RESP: begin
          r_last  <= r_gidx;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.db_in_valid = r_in_valid;
  assign bus.db_in_op    = r_op;
  assign bus.db_in_hash  = r_hash;
  assign bus.db_in_key   = r_key;
  assign bus.db_in_value = r_val;
  assign bus.rsp_valid   = r_rsp_valid;
  assign bus.rsp_hit     = r_rsp_hit;
  assign bus.rsp_flag    = r_rsp_flag;
  assign bus.busy        = (r_state != ST_IDLE);

endmodule

// File: tb/tb_db_req_arb.sv
// tb_db_req_arb: directed + random bench for db_req_arb.
// Transaction-timing reference model and engine stub.
module tb_db_req_arb;
  import db_req_arb_pkg::*;

  localparam int NREQ = 2;
  localparam int HS   = 32;
  localparam int KS   = 96;
  localparam int VS   = 32;
  localparam int HOLD = 6;
  localparam int LAT  = HOLD + 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  db_req_arb_if #(
    .NREQ(NREQ), .HASH_SIZE(HS),
    .KEY_SIZE(KS), .VAL_SIZE(VS)
  ) bus ();

  db_req_arb #(
    .NREQ(NREQ), .HASH_SIZE(HS),
    .KEY_SIZE(KS), .VAL_SIZE(VS),
    .HOLD_CYC(HOLD)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_chk = 0;
  int n_fail = 0;
  int n = 0;

  bit          m_have;
  int          m_acc;
  int          m_own;
  int          m_last;
  bit          m_hit;
  logic [3:0]  m_flag;
  bit          m_rhit;
  logic [3:0]  m_rflag;
  logic [3:0]  m_op;
  logic [HS-1:0] m_hash;
  logic [KS-1:0] m_key;
  logic [VS-1:0] m_val;

  bit         stub_rand;
  bit         force_ov;
  bit         auto_drop;
  int         d1, d2;
  logic [3:0] f1, f2;
  int         iv_at;

  task automatic chk(string tag, logic [127:0] obs,
                     logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_have  = 0;
    m_last  = NREQ - 1;
    m_hit   = 0;
    m_flag  = '0;
    m_rhit  = 0;
    m_rflag = '0;
    m_op    = '0;
    m_hash  = '0;
    m_key   = '0;
    m_val   = '0;
    iv_at   = -100;
  endtask

  function automatic int rr(logic [NREQ-1:0] v,
                            int last);
    for (int k = 1; k <= NREQ; k++)
      if (v[(last + k) % NREQ]) return (last + k) % NREQ;
    return -1;
  endfunction

  task automatic set_req(int p, logic [3:0] op,
                         logic [HS-1:0] h,
                         logic [KS-1:0] k,
                         logic [VS-1:0] v);
    bus.req_valid[p]         = 1'b1;
    bus.req_op[p*4 +: 4]     = op;
    bus.req_hash[p*HS +: HS] = h;
    bus.req_key[p*KS +: KS]  = k;
    bus.req_value[p*VS +: VS] = v;
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_ready"}, 128'(bus.req_ready), 128'(0));
    chk({tag, "_rspv"},  128'(bus.rsp_valid), 128'(0));
    chk({tag, "_hit"},   128'(bus.rsp_hit),   128'(0));
    chk({tag, "_flag"},  128'(bus.rsp_flag),  128'(0));
    chk({tag, "_inv"},   128'(bus.db_in_valid), 128'(0));
    chk({tag, "_op"},    128'(bus.db_in_op),  128'(0));
    chk({tag, "_hash"},  128'(bus.db_in_hash), 128'(0));
    chk({tag, "_key"},   128'(bus.db_in_key), 128'(0));
    chk({tag, "_val"},   128'(bus.db_in_value), 128'(0));
    chk({tag, "_busy"},  128'(bus.busy),      128'(0));
  endtask

  // One clock: stub drive, model + compare at negedge,
  // then advance past the next posedge.
  task automatic cyc();
    bit busy;
    int g;
    int age;
    logic [NREQ-1:0] e_rdy, e_rsp, rdy_seen;
    age = n - iv_at;
    if (stub_rand) begin
      bus.db_out_valid = ($urandom_range(0, 3) == 0);
      bus.db_out_flag  = 4'($urandom);
    end else begin
      bus.db_out_valid = force_ov || age == d1 || age == d2;
      bus.db_out_flag  = (age == d2) ? f2 : f1;
    end
    @(negedge clk);
    if (m_have && n > m_acc + LAT) m_have = 0;
    busy  = m_have && n > m_acc;
    e_rdy = '0;
    e_rsp = '0;
    g     = -1;
    if (!busy) begin
      g = rr(bus.req_valid, m_last);
      if (g >= 0) e_rdy[g] = 1'b1;
    end
    if (busy && n == m_acc + LAT) begin
      e_rsp[m_own] = 1'b1;
      m_rhit  = m_hit;
      m_rflag = m_flag;
    end
    chk("req_ready", 128'(bus.req_ready), 128'(e_rdy));
    chk("rsp_valid", 128'(bus.rsp_valid), 128'(e_rsp));
    chk("rsp_hit",   128'(bus.rsp_hit),   128'(m_rhit));
    chk("rsp_flag",  128'(bus.rsp_flag),  128'(m_rflag));
    chk("db_in_valid", 128'(bus.db_in_valid),
        128'(busy && n == m_acc + 1));
    chk("db_in_op",   128'(bus.db_in_op),   128'(m_op));
    chk("db_in_hash", 128'(bus.db_in_hash), 128'(m_hash));
    chk("db_in_key",  128'(bus.db_in_key),  128'(m_key));
    chk("db_in_value", 128'(bus.db_in_value), 128'(m_val));
    chk("busy", 128'(bus.busy), 128'(busy));
    if (busy && n >= m_acc + 2 && n <= m_acc + LAT - 1 &&
        bus.db_out_valid && !m_hit) begin
      m_hit  = 1;
      m_flag = bus.db_out_flag;
    end
    if (busy && n == m_acc + LAT) m_last = m_own;
    if (g >= 0) begin
      m_have = 1;
      m_acc  = n;
      m_own  = g;
      m_hit  = 0;
      m_flag = '0;
      m_op   = bus.req_op[g*4 +: 4];
      m_hash = bus.req_hash[g*HS +: HS];
      m_key  = bus.req_key[g*KS +: KS];
      m_val  = bus.req_value[g*VS +: VS];
    end
    if (bus.db_in_valid) iv_at = n;
    rdy_seen = bus.req_ready;
    @(posedge clk);
    n++;
    #1;
    if (auto_drop) bus.req_valid &= ~rdy_seen;
  endtask

  task automatic run(int k);
    for (int i = 0; i < k; i++) cyc();
  endtask

  task automatic do_reset(string tag);
    rst_n = 1'b0;
    bus.req_valid    = '0;
    bus.db_out_valid = 1'b0;
    @(posedge clk);
    #1 chk_zero(tag);
    @(posedge clk);
    #1 rst_n = 1'b1;
    m_reset();
  endtask

  initial begin
    bus.req_valid    = '0;
    bus.req_op       = '0;
    bus.req_hash     = '0;
    bus.req_key      = '0;
    bus.req_value    = '0;
    bus.db_out_valid = 1'b0;
    bus.db_out_flag  = '0;
    stub_rand = 0;
    force_ov  = 0;
    auto_drop = 1;
    d1 = -1; d2 = -1;
    f1 = '0; f2 = '0;
    m_reset();

    // reset state, request pending during reset
    set_req(0, 4'h0, 32'h1, 96'h2, 32'h3);
    @(posedge clk);
    #1 chk_zero("rst");
    bus.req_valid = '0;
    do_reset("rst2");

    // single GET hit on port 0
    d1 = 3; f1 = FLAG_ARREST;
    set_req(0, {3'b000, GET_REQ}, 32'hCAFE_0001,
            96'hA5A5_0000_1111_2222_3333_4444,
            32'hDEAD_BEEF);
    run(11);

    // SET miss on port 1
    d1 = -1;
    set_req(1, {3'b000, SET_REQ}, 32'h0BAD_F00D,
            96'h0123_4567_89AB_CDEF_FEDC_BA98,
            32'h1234_5678);
    run(11);

    // both ports continuously valid after reset
    do_reset("rst3");
    auto_drop = 0;
    d1 = 2; f1 = FLAG_SUSPECT;
    set_req(0, 4'h0, 32'h10, 96'h100, 32'h1000);
    set_req(1, 4'h1, 32'h20, 96'h200, 32'h2000);
    run(4 * (LAT + 1));
    bus.req_valid = '0;
    auto_drop = 1;
    run(2);

    // double strobe in one window, first wins
    d1 = 3; f1 = 4'h2;
    d2 = 5; f2 = 4'h6;
    set_req(0, 4'h0, 32'h33, 96'h3333, 32'h333);
    run(11);

    // stray strobe while idle
    d1 = -1; d2 = -1;
    force_ov = 1; f1 = 4'h8;
    run(2);
    force_ov = 0;
    set_req(1, 4'h1, 32'h44, 96'h4444, 32'h444);
    run(11);

    // async reset in the 3rd WAIT cycle
    set_req(0, 4'h0, 32'h55, 96'h5555, 32'h555);
    run(4);
    #2 rst_n = 1'b0;
    #1 chk_zero("async");
    bus.req_valid = '0;
    @(posedge clk);
    #1 chk_zero("hold");
    @(posedge clk);
    #1 rst_n = 1'b1;
    m_reset();
    set_req(1, 4'h1, 32'h66, 96'h6666, 32'h666);
    cyc();
    set_req(0, 4'h0, 32'h77, 96'h7777, 32'h777);
    run(20);

    // port 0 pulses once while port 1 is served
    set_req(1, 4'h1, 32'h88, 96'h8888, 32'h888);
    run(2);
    set_req(0, 4'h0, 32'h99, 96'h9999, 32'h999);
    cyc();
    bus.req_valid[0] = 1'b0;
    run(10);

    // randomized traffic and engine strobes
    stub_rand = 1;
    for (int i = 0; i < 400; i++) begin
      for (int p = 0; p < NREQ; p++) begin
        if (!bus.req_valid[p]) begin
          if ($urandom_range(0, 2) == 0)
            set_req(p, 4'($urandom), $urandom,
                    {$urandom, $urandom, $urandom},
                    $urandom);
        end else if ($urandom_range(0, 24) == 0) begin
          bus.req_valid[p] = 1'b0;
        end
      end
      cyc();
    end
    bus.req_valid = '0;
    run(LAT + 2);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
